// File: rtl/ibex_rf_wb_sequencer.sv
// Register-file write-port sequencer: merges LSU load returns and EX results
// into one registered write port, with a 2-entry EX FIFO, forwarding and a pending map.
module ibex_rf_wb_sequencer #(
  parameter int DataWidth         = 32,
  parameter bit DummyInstructions = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 ex_dummy_i,
  input  logic                 lsu_rvalid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_dummy_wb_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic [31:0]          pending_o
);

  logic [1:0]           r_cnt;
  logic [4:0]           r_q_waddr [2];
  logic [DataWidth-1:0] r_q_wdata [2];
  logic                 r_q_dummy [2];

  logic                 r_out_valid;
  logic [4:0]           r_out_waddr;
  logic [DataWidth-1:0] r_out_wdata;
  logic                 r_out_dummy;

  logic                 w_ex_acc;
  logic                 w_ex_dummy;
  logic                 w_ex_keep;
  logic                 w_lsu_keep;
  logic                 w_sel_valid;
  logic [4:0]           w_sel_waddr;
  logic [DataWidth-1:0] w_sel_wdata;
  logic                 w_sel_dummy;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_push_idx;
  logic [31:0]          w_pend;
  logic [4:0]           w_ra [2];
  logic                 w_fv [2];
  logic [DataWidth-1:0] w_fd [2];

  assign ex_ready_o = (r_cnt < 2'd2);
  assign w_ex_acc   = ex_valid_i & ex_ready_o;
  // A dummy x0 write survives filtering only when dummy instructions are enabled.
  assign w_ex_dummy = DummyInstructions & ex_dummy_i & (ex_waddr_i == 5'd0);
  assign w_ex_keep  = w_ex_acc & ((ex_waddr_i != 5'd0) | w_ex_dummy);
  assign w_lsu_keep = lsu_rvalid_i & (lsu_waddr_i != 5'd0);
  assign w_push_idx = (r_cnt == 2'd2) | ((r_cnt == 2'd1) & ~w_pop);

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_waddr = 5'd0;
    w_sel_wdata = '0;
    w_sel_dummy = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    if (w_lsu_keep) begin
      w_sel_valid = 1'b1;
      w_sel_waddr = lsu_waddr_i;
      w_sel_wdata = lsu_rdata_i;
      w_push      = w_ex_keep;
    end else if (r_cnt != 2'd0) begin
      w_sel_valid = 1'b1;
      w_sel_waddr = r_q_waddr[0];
      w_sel_wdata = r_q_wdata[0];
      w_sel_dummy = r_q_dummy[0];
      w_pop       = 1'b1;
      w_push      = w_ex_keep;
    end else if (w_ex_keep) begin
      w_sel_valid = 1'b1;
      w_sel_waddr = ex_waddr_i;
      w_sel_wdata = ex_wdata_i;
      w_sel_dummy = w_ex_dummy;
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  // FIFO storage: entry 0 is the head; a pop shifts entry 1 down before the push lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_q_waddr[i] <= 5'd0;
        r_q_wdata[i] <= '0;
        r_q_dummy[i] <= 1'b0;
      end
    end else begin
      r_cnt <= r_cnt - {1'b0, w_pop} + {1'b0, w_push};
      if (w_pop) begin
        r_q_waddr[0] <= r_q_waddr[1];
        r_q_wdata[0] <= r_q_wdata[1];
        r_q_dummy[0] <= r_q_dummy[1];
      end
      if (w_push) begin
        r_q_waddr[w_push_idx] <= ex_waddr_i;
        r_q_wdata[w_push_idx] <= ex_wdata_i;
        r_q_dummy[w_push_idx] <= w_ex_dummy;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_waddr <= 5'd0;
      r_out_wdata <= '0;
      r_out_dummy <= 1'b0;
    end else begin
      r_out_valid <= w_sel_valid;
      r_out_waddr <= w_sel_waddr;
      r_out_wdata <= w_sel_wdata;
      r_out_dummy <= w_sel_dummy;
    end
  end

  assign rf_we_o       = r_out_valid;
  assign rf_waddr_o    = r_out_waddr;
  assign rf_wdata_o    = r_out_wdata;
  assign rf_dummy_wb_o = r_out_dummy;

  always_comb begin
    w_pend = 32'd0;
    if (r_cnt != 2'd0) begin
      w_pend = w_pend | (32'd1 << r_q_waddr[0]);
    end else begin
      w_pend = w_pend;
    end
    if (r_cnt == 2'd2) begin
      w_pend = w_pend | (32'd1 << r_q_waddr[1]);
    end else begin
      w_pend = w_pend;
    end
    if (r_out_valid) begin
      w_pend = w_pend | (32'd1 << r_out_waddr);
    end else begin
      w_pend = w_pend;
    end
    w_pend[0] = 1'b0;
  end

  assign pending_o = w_pend;
  assign w_ra[0]   = raddr_a_i;
  assign w_ra[1]   = raddr_b_i;

  // Youngest match wins; dummy entries carry x0 and so never match a nonzero address.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_fv[p] = 1'b0;
      w_fd[p] = '0;
      if (w_ra[p] == 5'd0) begin
        w_fv[p] = 1'b0;
      end else if ((r_cnt == 2'd2) && (r_q_waddr[1] == w_ra[p])) begin
        w_fv[p] = 1'b1;
        w_fd[p] = r_q_wdata[1];
      end else if ((r_cnt != 2'd0) && (r_q_waddr[0] == w_ra[p])) begin
        w_fv[p] = 1'b1;
        w_fd[p] = r_q_wdata[0];
      end else if (r_out_valid && (r_out_waddr == w_ra[p])) begin
        w_fv[p] = 1'b1;
        w_fd[p] = r_out_wdata;
      end else begin
        w_fv[p] = 1'b0;
      end
    end
  end

  assign fwd_a_valid_o = w_fv[0];
  assign fwd_a_data_o  = w_fd[0];
  assign fwd_b_valid_o = w_fv[1];
  assign fwd_b_data_o  = w_fd[1];

endmodule

// File: tb/tb_ibex_rf_wb_sequencer.sv
// Directed bench for ibex_rf_wb_sequencer with hand-computed expectations.
module tb_ibex_rf_wb_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_ready_o, ex_dummy_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_rvalid_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_rdata_i;
  logic        rf_we_o, rf_dummy_wb_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  raddr_a_i, raddr_b_i;
  logic        fwd_a_valid_o, fwd_b_valid_o;
  logic [31:0] fwd_a_data_o, fwd_b_data_o;
  logic [31:0] pending_o;

  int n_asrt = 0;
  int n_fail = 0;

  ibex_rf_wb_sequencer #(.DataWidth(32), .DummyInstructions(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_waddr_i(ex_waddr_i),
    .ex_wdata_i(ex_wdata_i), .ex_dummy_i(ex_dummy_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_rdata_i(lsu_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_dummy_wb_o(rf_dummy_wb_o),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
    .fwd_a_valid_o(fwd_a_valid_o), .fwd_b_valid_o(fwd_b_valid_o),
    .fwd_a_data_o(fwd_a_data_o), .fwd_b_data_o(fwd_b_data_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ex_valid_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0; ex_dummy_i = 1'b0;
    lsu_rvalid_i = 1'b0; lsu_waddr_i = 5'd0; lsu_rdata_i = 32'd0;
  endtask

  task automatic ex(input logic [4:0] a, input logic [31:0] d, input logic dm);
    ex_valid_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d; ex_dummy_i = dm;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [31:0] d);
    lsu_rvalid_i = 1'b1; lsu_waddr_i = a; lsu_rdata_i = d;
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {63'd0, rf_we_o}, 64'd1);
    chk({tag, "_waddr"}, {59'd0, rf_waddr_o}, {59'd0, a});
    chk({tag, "_wdata"}, {32'd0, rf_wdata_o}, {32'd0, d});
  endtask

  initial begin
    idle();
    raddr_a_i = 5'd0; raddr_b_i = 5'd0;
    rst_ni = 1'b0;
    #1;
    chk("rst_we", {63'd0, rf_we_o}, 64'd0);
    chk("rst_waddr", {59'd0, rf_waddr_o}, 64'd0);
    chk("rst_wdata", {32'd0, rf_wdata_o}, 64'd0);
    chk("rst_dummy", {63'd0, rf_dummy_wb_o}, 64'd0);
    chk("rst_pending", {32'd0, pending_o}, 64'd0);
    chk("rst_fwd_a", {63'd0, fwd_a_valid_o}, 64'd0);
    chk("rst_ready", {63'd0, ex_ready_o}, 64'd1);
    cyc(); cyc();
    rst_ni = 1'b1;
    cyc();

    // Single EX write
    ex(5'd5, 32'hDEADBEEF, 1'b0);
    #1 chk("single_ready", {63'd0, ex_ready_o}, 64'd1);
    cyc(); idle();
    wr("single", 5'd5, 32'hDEADBEEF);
    chk("single_pend", {32'd0, pending_o}, 64'h20);
    cyc();
    chk("single_we_off", {63'd0, rf_we_o}, 64'd0);
    chk("single_pend_off", {32'd0, pending_o}, 64'd0);

    // Collision: LSU first, EX buffered
    lsu(5'd3, 32'h11); ex(5'd4, 32'h22, 1'b0);
    cyc(); idle();
    wr("coll1", 5'd3, 32'h11);
    chk("coll1_pend", {32'd0, pending_o}, 64'h18);
    cyc();
    wr("coll2", 5'd4, 32'h22);
    chk("coll2_pend", {32'd0, pending_o}, 64'h10);
    cyc();
    chk("coll_we_off", {63'd0, rf_we_o}, 64'd0);

    // Backpressure: LSU x10..x13 for 4 cycles while EX offers x6, x7, x8
    lsu(5'd10, 32'h100); ex(5'd6, 32'h66, 1'b0);
    #1 chk("bp_ready0", {63'd0, ex_ready_o}, 64'd1);
    cyc();
    lsu(5'd11, 32'h101); ex(5'd7, 32'h77, 1'b0);
    chk("bp_ready1", {63'd0, ex_ready_o}, 64'd1);
    cyc();
    lsu(5'd12, 32'h102); ex(5'd8, 32'h88, 1'b0);
    chk("bp_ready2", {63'd0, ex_ready_o}, 64'd0);
    chk("bp_pend2", {32'd0, pending_o}, 64'h8C0);
    cyc();
    lsu(5'd13, 32'h103);
    chk("bp_ready3", {63'd0, ex_ready_o}, 64'd0);
    cyc();
    lsu_rvalid_i = 1'b0;
    wr("bp_lsu13", 5'd13, 32'h103);
    chk("bp_ready4", {63'd0, ex_ready_o}, 64'd0);
    cyc();
    wr("bp_x6", 5'd6, 32'h66);
    chk("bp_ready5", {63'd0, ex_ready_o}, 64'd1);
    cyc(); idle();
    wr("bp_x7", 5'd7, 32'h77);
    cyc();
    wr("bp_x8", 5'd8, 32'h88);
    cyc();
    chk("bp_we_off", {63'd0, rf_we_o}, 64'd0);

    // Forwarding: FIFO holds x9=A then x9=B behind LSU traffic
    lsu(5'd20, 32'h200); ex(5'd9, 32'hA, 1'b0);
    cyc();
    lsu(5'd21, 32'h201); ex(5'd9, 32'hB, 1'b0);
    cyc(); idle();
    lsu(5'd22, 32'h202);
    raddr_a_i = 5'd9; raddr_b_i = 5'd0;
    #1;
    chk("fwd_a_valid", {63'd0, fwd_a_valid_o}, 64'd1);
    chk("fwd_a_data", {32'd0, fwd_a_data_o}, 64'hB);
    chk("fwd_b_x0_valid", {63'd0, fwd_b_valid_o}, 64'd0);
    chk("fwd_b_x0_data", {32'd0, fwd_b_data_o}, 64'd0);
    raddr_b_i = 5'd21;
    #1;
    chk("fwd_b_out_valid", {63'd0, fwd_b_valid_o}, 64'd1);
    chk("fwd_b_out_data", {32'd0, fwd_b_data_o}, 64'h201);
    raddr_b_i = 5'd0;
    cyc(); idle();
    wr("fwd_lsu22", 5'd22, 32'h202);
    cyc();
    wr("fwd_xA", 5'd9, 32'hA);
    chk("fwd_a_fifo_over_out", {32'd0, fwd_a_data_o}, 64'hB);
    cyc();
    wr("fwd_xB", 5'd9, 32'hB);
    chk("fwd_a_out_valid", {63'd0, fwd_a_valid_o}, 64'd1);
    chk("fwd_a_out_data", {32'd0, fwd_a_data_o}, 64'hB);
    cyc();
    chk("fwd_a_none", {63'd0, fwd_a_valid_o}, 64'd0);
    chk("fwd_a_none_data", {32'd0, fwd_a_data_o}, 64'd0);
    raddr_a_i = 5'd0;

    // x0 filtering and dummy write
    ex(5'd0, 32'h55, 1'b0);
    #1 chk("x0_ready", {63'd0, ex_ready_o}, 64'd1);
    cyc(); idle();
    chk("x0_we", {63'd0, rf_we_o}, 64'd0);
    chk("x0_pend", {32'd0, pending_o}, 64'd0);
    ex(5'd0, 32'h66, 1'b1);
    cyc(); idle();
    wr("dummy", 5'd0, 32'h66);
    chk("dummy_flag", {63'd0, rf_dummy_wb_o}, 64'd1);
    chk("dummy_pend", {32'd0, pending_o}, 64'd0);
    chk("dummy_fwd", {63'd0, fwd_a_valid_o}, 64'd0);
    cyc();
    chk("dummy_we_off", {63'd0, rf_we_o}, 64'd0);
    chk("dummy_flag_off", {63'd0, rf_dummy_wb_o}, 64'd0);

    // Reset with FIFO full
    lsu(5'd1, 32'h301); ex(5'd6, 32'h601, 1'b0);
    cyc();
    lsu(5'd2, 32'h302); ex(5'd7, 32'h701, 1'b0);
    cyc(); idle();
    chk("rst2_full", {63'd0, ex_ready_o}, 64'd0);
    chk("rst2_pre_we", {63'd0, rf_we_o}, 64'd1);
    raddr_a_i = 5'd6;
    rst_ni = 1'b0;
    #1;
    chk("rst2_we", {63'd0, rf_we_o}, 64'd0);
    chk("rst2_waddr", {59'd0, rf_waddr_o}, 64'd0);
    chk("rst2_wdata", {32'd0, rf_wdata_o}, 64'd0);
    chk("rst2_pend", {32'd0, pending_o}, 64'd0);
    chk("rst2_fwd", {63'd0, fwd_a_valid_o}, 64'd0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("rst2_post_we", {63'd0, rf_we_o}, 64'd0);
    chk("rst2_post_ready", {63'd0, ex_ready_o}, 64'd1);
    cyc();
    chk("rst2_post_we2", {63'd0, rf_we_o}, 64'd0);
    chk("rst2_post_pend", {32'd0, pending_o}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
